// File: rtl/dc_encoder.sv
// Quadrature encoder front end: synchronizes and deglitches A/B, decodes x4 steps
// into a signed position, and measures signed speed over a fixed gate window.
module dc_encoder #(
    parameter int CLK_FRE  = 50,
    parameter int GATE_MS  = 10,
    parameter int FILT_LEN = 4,
    parameter int POS_W    = 32,
    parameter int SPD_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    enc_clr,
    output logic [POS_W-1:0]        pos,
    output logic signed [SPD_W-1:0] speed,
    output logic                    speed_valid,
    output logic                    dir,
    output logic                    enc_err
);

    localparam int GATE_CYC = CLK_FRE * 1000 * GATE_MS;
    localparam int GATE_W   = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam int FCNT_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
    localparam int ACC_W    = SPD_W + 1;

    // Saturation limits, all expressed at the ACC_W+1 bit sum width.
    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0] SPD_MAX = {3'b000, {(SPD_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SPD_MIN = {3'b111, {(SPD_W-1){1'b0}}};

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILL
    } step_e;

    // Channel vectors are {a, b}.
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        filt;
    logic [1:0]        prev;
    logic [FCNT_W-1:0] fcnt [2];

    step_e                    step;
    logic signed [ACC_W:0]    step_delta;
    logic signed [ACC_W:0]    acc_sum;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sat;
    logic signed [SPD_W-1:0]  speed_next;
    logic [GATE_W-1:0]        gate_cnt;
    logic                     terminal;

    // NOTE: every register below uses non-blocking assignment so all flops
    // sample pre-edge values; blocking here would collapse the synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int ch = 0; ch < 2; ch++) fcnt[ch] <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            for (int ch = 0; ch < 2; ch++) begin
                if (sync2[ch] == filt[ch]) begin
                    fcnt[ch] <= '0;
                end else if (fcnt[ch] == FCNT_W'(FILT_LEN - 1)) begin
                    filt[ch] <= sync2[ch];
                    fcnt[ch] <= '0;
                end else begin
                    fcnt[ch] <= fcnt[ch] + FCNT_W'(1);
                end
            end
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        step = STEP_NONE;
        unique case ({prev, filt})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_FWD;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step = STEP_REV;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step = STEP_ILL;
            default:                                step = STEP_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            pos     <= '0;
            enc_err <= 1'b0;
        end else begin
            prev <= filt;
            if (enc_clr) begin
                pos     <= '0;
                enc_err <= 1'b0;
            end else begin
                if (step == STEP_FWD) pos <= pos + POS_W'(1);
                if (step == STEP_REV) pos <= pos - POS_W'(1);
                if (step == STEP_ILL) enc_err <= 1'b1;
            end
        end
    end

    always_comb begin
        step_delta = '0;
        if (step == STEP_FWD) step_delta = {{ACC_W{1'b0}}, 1'b1};
        if (step == STEP_REV) step_delta = '1;
        acc_sum  = {acc[ACC_W-1], acc} + step_delta;
        terminal = (gate_cnt == GATE_W'(GATE_CYC - 1));

        acc_sat = acc_sum[ACC_W-1:0];
        if (acc_sum > ACC_MAX) acc_sat = ACC_MAX[ACC_W-1:0];
        if (acc_sum < ACC_MIN) acc_sat = ACC_MIN[ACC_W-1:0];

        speed_next = acc_sum[SPD_W-1:0];
        if (acc_sum > SPD_MAX) speed_next = SPD_MAX[SPD_W-1:0];
        if (acc_sum < SPD_MIN) speed_next = SPD_MIN[SPD_W-1:0];
    end

    // Steps decoded under enc_clr still land in the window accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt    <= '0;
            acc         <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
            dir         <= 1'b0;
        end else begin
            speed_valid <= terminal;
            if (terminal) begin
                gate_cnt <= '0;
                acc      <= '0;
                speed    <= speed_next;
                if (speed_next[SPD_W-1]) begin
                    dir <= 1'b0;
                end else if (speed_next != '0) begin
                    dir <= 1'b1;
                end
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                acc      <= acc_sat;
            end
        end
    end

endmodule

// File: tb/tb_dc_encoder.sv
// Self-checking bench for dc_encoder: quadrature stimulus against an event-level
// model that schedules each accepted pin change to land FILT_LEN+3 edges later.
module tb_dc_encoder;

    localparam int G   = 1000;
    localparam int FL  = 4;
    localparam int LAT = FL + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              enc_a;
    logic              enc_b;
    logic              enc_clr;
    logic [31:0]       pos;
    logic signed [7:0] speed;
    logic              speed_valid;
    logic              dir;
    logic              enc_err;

    dc_encoder #(
        .CLK_FRE(1), .GATE_MS(1), .FILT_LEN(FL), .POS_W(32), .SPD_W(8)
    ) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_clr(enc_clr),
        .pos(pos), .speed(speed), .speed_valid(speed_valid), .dir(dir),
        .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int at;
        int delta;
        bit illegal;
    } land_t;

    land_t       land_q[$];
    int          edge_n;
    logic [31:0] m_pos;
    int          m_acc;
    int          m_speed;
    bit          m_dir;
    bit          m_err;
    int          idx;
    int          checks;
    int          failures;
    logic [1:0]  codes [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Reference model: applies scheduled landings, enc_clr and the gate window.
    always @(posedge clk or posedge rst) begin : model
        int          e;
        logic [31:0] p;
        int          a;
        int          s;
        bit          d;
        bit          er;
        land_t       ev;
        if (rst) begin
            edge_n  <= 0;
            m_pos   <= '0;
            m_acc   <= 0;
            m_speed <= 0;
            m_dir   <= 1'b0;
            m_err   <= 1'b0;
            land_q.delete();
        end else begin
            e  = edge_n + 1;
            p  = m_pos;
            a  = m_acc;
            s  = m_speed;
            d  = m_dir;
            er = m_err;
            while (land_q.size() > 0 && land_q[0].at <= e) begin
                ev = land_q.pop_front();
                if (ev.illegal) begin
                    er = 1'b1;
                end else begin
                    p = p + 32'(ev.delta);
                    a = clamp(a + ev.delta, -256, 255);
                end
            end
            if (enc_clr) begin
                p  = '0;
                er = 1'b0;
            end
            if (e % G == 0) begin
                s = clamp(a, -128, 127);
                if (s > 0) d = 1'b1;
                else if (s < 0) d = 1'b0;
                a = 0;
            end
            edge_n  <= e;
            m_pos   <= p;
            m_acc   <= a;
            m_speed <= s;
            m_dir   <= d;
            m_err   <= er;
        end
    end

    // Call right after a negedge: the next posedge samples the new level.
    task automatic launch_step(input int d);
        idx = (idx + d) & 3;
        {enc_a, enc_b} = codes[idx];
        land_q.push_back('{edge_n + LAT, d, 1'b0});
    endtask

    task automatic launch_illegal();
        idx = (idx + 2) & 3;
        {enc_a, enc_b} = codes[idx];
        land_q.push_back('{edge_n + LAT, 0, 1'b1});
    endtask

    task automatic test_reset();
        rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_clr = 1'b0; idx = 0;
        repeat (3) @(negedge clk);
        checks++; if (pos !== 32'd0) begin failures++; $display("FAIL reset_pos got=%h want=0", pos); end
        checks++; if (speed !== 8'sd0) begin failures++; $display("FAIL reset_speed got=%0d want=0", speed); end
        checks++; if (speed_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", speed_valid); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%b want=0", dir); end
        checks++; if (enc_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", enc_err); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_forward();
        int land;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            launch_step(1);
            land = edge_n + LAT;
            while (edge_n < land - 1) @(negedge clk);
            checks++; if (pos !== 32'(i)) begin failures++; $display("FAIL fwd_early step=%0d got=%0d want=%0d", i, pos, i); end
            @(negedge clk);
            checks++; if (pos !== 32'(i + 1)) begin failures++; $display("FAIL fwd_land step=%0d got=%0d want=%0d", i, pos, i + 1); end
            repeat (13) @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        int land_up;
        int land_dn;
        @(negedge clk);
        enc_a = 1'b1;
        repeat (3) @(negedge clk);
        enc_a = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (pos !== 32'd8) begin failures++; $display("FAIL glitch3_pos got=%0d want=8", pos); end
        launch_step(1);
        land_up = edge_n + LAT;
        repeat (4) @(negedge clk);
        launch_step(-1);
        land_dn = edge_n + LAT;
        while (edge_n < land_up) @(negedge clk);
        checks++; if (pos !== 32'd9) begin failures++; $display("FAIL glitch4_up got=%0d want=9", pos); end
        while (edge_n < land_dn) @(negedge clk);
        checks++; if (pos !== 32'd8) begin failures++; $display("FAIL glitch4_down got=%0d want=8", pos); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reverse();
        @(negedge clk);
        enc_clr = 1'b1;
        @(negedge clk);
        enc_clr = 1'b0;
        checks++; if (pos !== 32'd0) begin failures++; $display("FAIL rev_clear got=%h want=0", pos); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            launch_step(-1);
            repeat (19) @(negedge clk);
        end
        checks++; if (pos !== 32'hFFFF_FFFD) begin failures++; $display("FAIL rev_wrap got=%h want=fffffffd", pos); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        launch_illegal();
        repeat (30) @(negedge clk);
        checks++; if (pos !== 32'hFFFF_FFFD) begin failures++; $display("FAIL ill_pos got=%h want=fffffffd", pos); end
        checks++; if (enc_err !== 1'b1) begin failures++; $display("FAIL ill_err got=%b want=1", enc_err); end
        enc_clr = 1'b1;
        @(negedge clk);
        enc_clr = 1'b0;
        checks++; if (pos !== 32'd0) begin failures++; $display("FAIL ill_clr_pos got=%h want=0", pos); end
        checks++; if (enc_err !== 1'b0) begin failures++; $display("FAIL ill_clr_err got=%b want=0", enc_err); end
    endtask

    task automatic test_speed();
        int dirs [3] = '{1, -1, 1};
        int gaps [3] = '{50, 25, 2};
        int want [3] = '{20, -40, 127};
        bit wdir [3] = '{1'b1, 1'b0, 1'b1};
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 2200; c++) begin
                @(negedge clk);
                checks++;
                if (speed_valid !== (edge_n % G == 0)) begin
                    failures++; $display("FAIL spd_pulse edge=%0d got=%b", edge_n, speed_valid);
                end
                if (speed_valid) begin
                    checks++; if (speed !== 8'(m_speed)) begin failures++; $display("FAIL spd_value edge=%0d got=%0d want=%0d", edge_n, speed, m_speed); end
                    checks++; if (dir !== m_dir) begin failures++; $display("FAIL spd_dir edge=%0d got=%b want=%b", edge_n, dir, m_dir); end
                end
                if (c % gaps[ph] == 0) launch_step(dirs[ph]);
            end
            checks++; if (speed !== 8'(want[ph])) begin failures++; $display("FAIL spd_phase%0d got=%0d want=%0d", ph, speed, want[ph]); end
            checks++; if (dir !== wdir[ph]) begin failures++; $display("FAIL spd_phase%0d_dir got=%b want=%b", ph, dir, wdir[ph]); end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        int gap;
        for (int n = 0; n < 60; n++) begin
            gap = int'($urandom_range(4, 30));
            @(negedge clk);
            launch_step(($urandom_range(0, 1) == 1) ? 1 : -1);
            for (int c = 0; c < gap; c++) begin
                @(negedge clk);
                if (speed_valid || (edge_n % G == 0)) begin
                    checks++; if (speed_valid !== 1'b1 || speed !== 8'(m_speed)) begin
                        failures++; $display("FAIL rnd_speed edge=%0d valid=%b got=%0d want=%0d", edge_n, speed_valid, speed, m_speed);
                    end
                end
            end
        end
        repeat (15) @(negedge clk);
        checks++; if (pos !== m_pos) begin failures++; $display("FAIL rnd_pos got=%h want=%h", pos, m_pos); end
        checks++; if (enc_err !== m_err) begin failures++; $display("FAIL rnd_err got=%b want=%b", enc_err, m_err); end
    endtask

    task automatic test_reset_mid();
        int seen;
        for (int k = 0; k < 1100 && (edge_n % G) != 600; k++) @(negedge clk);
        checks++; if ((edge_n % G) != 600) begin failures++; $display("FAIL rmid_reach got=%0d want=600", edge_n % G); end
        rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; idx = 0;
        #1;
        checks++; if ({pos, speed, speed_valid, dir, enc_err} !== '0) begin
            failures++; $display("FAIL rmid_outputs pos=%h speed=%0d valid=%b dir=%b err=%b", pos, speed, speed_valid, dir, enc_err);
        end
        repeat (3) begin
            @(negedge clk);
            checks++; if (speed_valid !== 1'b0) begin failures++; $display("FAIL rmid_nopulse got=%b want=0", speed_valid); end
        end
        rst = 1'b0;
        seen = -1;
        for (int k = 0; k < 1100 && seen < 0; k++) begin
            @(negedge clk);
            if (speed_valid) seen = edge_n;
        end
        checks++; if (seen != 1000) begin failures++; $display("FAIL rmid_first_pulse got=%0d want=1000", seen); end
        checks++; if (speed !== 8'sd0 || dir !== 1'b0) begin failures++; $display("FAIL rmid_speed got=%0d/%b want=0/0", speed, dir); end
    endtask

    task automatic test_clr_coincident();
        int land;
        int seen;
        @(negedge clk);
        launch_step(1);
        repeat (20) @(negedge clk);
        checks++; if (pos !== 32'd1) begin failures++; $display("FAIL clr_pre got=%0d want=1", pos); end
        launch_step(1);
        land = edge_n + LAT;
        while (edge_n < land - 1) @(negedge clk);
        enc_clr = 1'b1;
        @(negedge clk);
        enc_clr = 1'b0;
        checks++; if (pos !== 32'd0) begin failures++; $display("FAIL clr_step_pos got=%0d want=0", pos); end
        seen = 0;
        for (int k = 0; k < 1100 && !seen; k++) begin
            @(negedge clk);
            if (speed_valid) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL clr_pulse_timeout got=none want=pulse"); end
        checks++; if (speed !== 8'sd2 || speed !== 8'(m_speed)) begin failures++; $display("FAIL clr_speed got=%0d want=2 model=%0d", speed, m_speed); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL clr_dir got=%b want=1", dir); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_forward();
        test_glitch();
        test_reverse();
        test_illegal();
        test_speed();
        test_random();
        test_reset_mid();
        test_clr_coincident();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
